// File: rtl/modred_pkg.sv
// Shared types and elaboration-time helpers for the sequential modular reducer.
// MODRED_CHUNK2_EN selects two chunks per accumulate cycle instead of one.
package modred_pkg;

    typedef enum logic [2:0] {IDLE, ACC, FOLD, CORR, DONE} state_t;

`ifdef MODRED_CHUNK2_EN
    localparam int CHUNK_STEP = 2;
    localparam int ACC_EXTRA  = 1;
`else
    localparam int CHUNK_STEP = 1;
    localparam int ACC_EXTRA  = 0;
`endif

    function automatic int clog2(input longint v);
        int     r;
        longint t;
        r = 0;
        t = 1;
        while (t < v) begin
            t = t << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int pow2_mod(input int e, input int m);
        longint r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * 2) % m;
        return int'(r);
    endfunction

    function automatic int n_chunk(input int w, input int k);
        return (w + k - 1) / k;
    endfunction

    function automatic int acc_width(input int n, input int k);
        return 2 * k + clog2(n + 1) + ACC_EXTRA;
    endfunction

endpackage

// File: rtl/mod_fold_step.sv
// One folding step: acc_lo + acc_hi * (2^K mod MOD), congruent to acc and never wider.
module mod_fold_step
    import modred_pkg::*;
#(
    parameter int ACC_W = 26,
    parameter int K     = 11,
    parameter int C1    = 37
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] fold_o,
    output logic             hi_zero_o
);

    logic [ACC_W-K-1:0] acc_hi;

    assign acc_hi    = acc_i[ACC_W-1:K];
    // C1 < 2^(K-1), so the product plus a K-bit low part still fits in ACC_W bits
    assign fold_o    = ACC_W'(acc_i[K-1:0]) + ACC_W'(acc_hi) * ACC_W'(C1);
    assign hi_zero_o = (acc_hi == '0);

endmodule

// File: rtl/mod_reduce_seq.sv
// Multi-cycle X mod MOD: chunked multiply-accumulate, fold until < 2^K, one correction.
// Define MODRED_CHUNK2_EN to consume two chunks per ACC cycle (same residues, lower latency).
module mod_reduce_seq
    import modred_pkg::*;
#(
    parameter int W_IN = 100,
    parameter int MOD  = 2011,
    parameter int K    = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W_IN-1:0] in_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K-1:0]    out_r,
    output logic            busy
);

    localparam int N_CHUNK = n_chunk(W_IN, K);
    localparam int ACC_W   = acc_width(N_CHUNK, K);
    localparam int STEP    = CHUNK_STEP;
    localparam int N_STEPS = (N_CHUNK + STEP - 1) / STEP;
    localparam int N_PAD   = N_STEPS * STEP;
    localparam int PAD_W   = N_PAD * K;
    localparam int CNT_W   = clog2(N_STEPS + 1);
    localparam int C1      = pow2_mod(K, MOD);

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [K-1:0]       out_r_q;
    logic               busy_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   idx_q;
    logic [PAD_W-1:0]   shreg_q;

    logic [STEP*K-1:0]  w_sel;
    logic [ACC_W-1:0]   mac_d;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   fold_d;
    logic               hi_zero;
    logic [K-1:0]       corr_d;
    wire  [PAD_W-1:0]   w_all;

    // Constant weight table C[i] = 2^(K*i) mod MOD, padded chunk weights are harmless
    generate
        for (genvar gi = 0; gi < N_PAD; gi++) begin : g_weight
            assign w_all[gi*K +: K] = K'(pow2_mod(K * gi, MOD));
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_STEPS; i++) begin
            if (idx_q == CNT_W'(i)) w_sel = w_all[i*STEP*K +: STEP*K];
        end
        mac_d = '0;
        for (int j = 0; j < STEP; j++) begin
            mac_d = mac_d + ACC_W'(shreg_q[j*K +: K]) * ACC_W'(w_sel[j*K +: K]);
        end
        acc_d  = acc_q + mac_d;
        corr_d = K'((acc_q >= ACC_W'(MOD)) ? acc_q - ACC_W'(MOD) : acc_q);
    end

    mod_fold_step #(
        .ACC_W (ACC_W),
        .K     (K),
        .C1    (C1)
    ) u_fold (
        .acc_i     (acc_q),
        .fold_o    (fold_d),
        .hi_zero_o (hi_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q    <= PAD_W'(in_x);
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q >> (STEP * K);
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == CNT_W'(N_STEPS - 1)) state_q <= FOLD;
                end
                FOLD: begin
                    if (hi_zero) state_q <= CORR;
                    else         acc_q   <= fold_d;
                end
                CORR: begin
                    out_r_q     <= corr_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Return to IDLE only; a waiting operand is taken on the following edge
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Self-checking bench for mod_reduce_seq: directed vectors, backpressure, aborts, random streams.
module tb_mod_reduce_seq;

`ifdef MODRED_CHUNK2_EN
    localparam int N_STEPS = 5;
    localparam int LAT_MAX = 13;
`else
    localparam int N_STEPS = 10;
    localparam int LAT_MAX = 18;
`endif
    localparam int NR = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [99:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_r;
    logic        busy;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [63:0] in_x2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [10:0] out_r2;
    logic        busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_reduce_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    mod_reduce_seq #(.W_IN(64), .MOD(2039), .K(11)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_x      (in_x2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_r     (out_r2),
        .busy      (busy2)
    );

    typedef struct {
        string       name;
        logic [99:0] x;
        logic [10:0] r;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [99:0] rand_x100();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: t = '0;
            1: t = '1;
            2: t = 128'($urandom) * 128'd2011;
            3: t = 128'($urandom_range(0, 4095));
            default: ;
        endcase
        return t[99:0];
    endfunction

    function automatic logic [63:0] rand_x64();
        logic [63:0] t;
        t = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: t = '0;
            1: t = '1;
            2: t = 64'($urandom) * 64'd2039;
            3: t = 64'($urandom_range(0, 4095));
            default: ;
        endcase
        return t;
    endfunction

    // Full operation on the default instance with immediate output acceptance
    task automatic run_op(input string name, input logic [99:0] x,
                          output logic [10:0] r, output int lat);
        int n;
        @(negedge clk);
        in_x = x;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_valid"}, out_valid, 1);
        r = out_r;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, out_valid, 0);
        chk({name, "_ready_back"}, in_ready, 1);
        $display("op %s x=%0h r=%0d lat=%0d", name, x, r, lat);
    endtask

    initial begin
        logic [10:0] r;
        logic [99:0] big;
        int lat;
        int seen;
        int acc1, acc2, done1, done2;
        logic [99:0] q1[$];
        logic [63:0] q2[$];
        logic [99:0] x1;
        logic [63:0] x2;

        // Reset behaviour
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_busy", busy, 0);

        // Directed residue table
        big = '0;
        vecs[0] = '{"x2011", 100'd2011, 11'd0};
        vecs[1] = '{"x2010", 100'd2010, 11'd2010};
        vecs[2] = '{"x2048", 100'd2048, 11'd37};
        vecs[3] = '{"x4022", 100'd4022, 11'd0};
        big[99] = 1'b1;
        vecs[4] = '{"pow99", big, 11'd725};
        big = '1;
        vecs[5] = '{"ones100", big, 11'd1449};
        vecs[6] = '{"zero", 100'd0, 11'd0};
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].name, vecs[i].x, r, lat);
            chk({vecs[i].name, "_residue"}, r, vecs[i].r);
            chk({vecs[i].name, "_latency_ok"}, (lat <= LAT_MAX) ? 1 : 0, 1);
        end

        // Backpressure with a waiting operand
        @(negedge clk);
        in_x = 100'd2048;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 60) begin
            @(negedge clk);
            seen++;
        end
        chk("bp_valid", out_valid, 1);
        in_x = 100'd4022;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_r", out_r, 37);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_idle", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_pending_taken", busy, 1);
        seen = 0;
        while (!out_valid && seen < 60) begin
            @(negedge clk);
            seen++;
        end
        chk("bp_pending_r", out_r, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("op backpressure x=2048 then x=4022 done");

        // Abort mid-ACC
        big = '1;
        in_x = big;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_acc_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_acc_idle", busy, 0);
        chk("abort_acc_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_acc_no_valid", seen, 0);
        run_op("after_acc_abort", 100'd2048, r, lat);
        chk("after_acc_abort_r", r, 37);

        // Abort mid-FOLD
        @(negedge clk);
        in_x = big;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (N_STEPS + 1) @(negedge clk);
        chk("abort_fold_busy", busy, 1);
        chk("abort_fold_not_done", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_fold_idle", busy, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_fold_no_valid", seen, 0);
        run_op("after_fold_abort", 100'd2010, r, lat);
        chk("after_fold_abort_r", r, 2010);

        // Random streams on both configurations against X % MOD
        acc1 = 0; acc2 = 0; done1 = 0; done2 = 0;
        for (int cyc = 0; cyc < 80000 && (done1 < NR || done2 < NR); cyc++) begin
            @(negedge clk);
            in_valid  = (acc1 < NR) && ($urandom_range(0, 3) != 0);
            in_x      = rand_x100();
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid2  = (acc2 < NR) && ($urandom_range(0, 3) != 0);
            in_x2      = rand_x64();
            out_ready2 = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                q1.push_back(in_x);
                acc1++;
            end
            if (out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    chk("rnd1_unexpected_output", 1, 0);
                end else begin
                    x1 = q1.pop_front();
                    chk("rnd1_residue", out_r, longint'(x1 % 100'd2011));
                    $display("rnd1 x=%0h r=%0d", x1, out_r);
                end
                done1++;
            end
            if (in_valid2 && in_ready2) begin
                q2.push_back(in_x2);
                acc2++;
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    chk("rnd2_unexpected_output", 1, 0);
                end else begin
                    x2 = q2.pop_front();
                    chk("rnd2_residue", out_r2, longint'(x2 % 64'd2039));
                    $display("rnd2 x=%0h r=%0d", x2, out_r2);
                end
                done2++;
            end
        end
        chk("rnd1_completed", done1, NR);
        chk("rnd2_completed", done2, NR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
